// File: rtl/sync_perf_monitor_pkg.sv
// Shared types and constants for the per-tile sync performance monitor.
package sync_perf_monitor_pkg;

    localparam int unsigned THREAD_NUMB       = 8;
    localparam int unsigned PERF_CNT_W_MAX    = 32;
    localparam int unsigned PERF_EVENT_DETECT = 0;
    localparam int unsigned PERF_EVENT_SEND   = 1;

    typedef logic [7:0] barrier_t;

    // count is sized for the widest supported counter; narrower counters zero-extend
    typedef struct packed {
        logic [7:0]                tile_id;
        logic [7:0]                thread_idx;
        logic [3:0]                event_idx;
        barrier_t                  barrier;
        logic [PERF_CNT_W_MAX-1:0] count;
        logic                      saturated;
    } perf_record_t;

    function automatic perf_record_t make_record(
        input int unsigned               tile,
        input int unsigned               thread,
        input int unsigned               evt,
        input barrier_t                  bar,
        input logic [PERF_CNT_W_MAX-1:0] cnt,
        input logic                      sat
    );
        perf_record_t r;
        r.tile_id    = 8'(tile);
        r.thread_idx = 8'(thread);
        r.event_idx  = 4'(evt);
        r.barrier    = bar;
        r.count      = cnt;
        r.saturated  = sat;
        return r;
    endfunction

endpackage

// File: rtl/sync_perf_monitor_if.sv
// Record stream from the performance monitor to its consumer.
interface sync_perf_monitor_if;

    logic                               rec_valid;
    logic                               rec_ready;
    sync_perf_monitor_pkg::perf_record_t rec_data;

    modport master (output rec_valid, output rec_data, input rec_ready);
    modport slave  (input rec_valid, input rec_data, output rec_ready);

endinterface

// File: rtl/sync_perf_monitor_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, pointer moves past the winner on each grant.
module perf_rr_arbiter #(
    parameter  int unsigned N  = 16,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = IW'((32'(ptr) + i) % N);
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/sync_perf_monitor.sv
// Per-tile sync performance monitor: measures event-high intervals per (event, thread)
// pair and streams each measurement as a tagged record through a small FIFO.
module sync_perf_monitor
    import sync_perf_monitor_pkg::*;
#(
    parameter  int unsigned TILE_ID_PAR = 0,
    parameter  int unsigned NUM_THREADS = THREAD_NUMB,
    parameter  int unsigned NUM_EVENTS  = 2,
    parameter  int unsigned CNT_W       = 32,
    parameter  int unsigned FIFO_DEPTH  = 8,
    parameter  int unsigned DROP_W      = 16,
    localparam int unsigned TW          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic                                   clear,
    input  logic [NUM_EVENTS-1:0][NUM_THREADS-1:0] perf_events,
    input  logic                                   bar_capture_valid,
    input  logic [TW-1:0]                          bar_capture_thread,
    input  barrier_t                               bar_capture_id,
    sync_perf_monitor_if.master                    rec_if,
    output logic [DROP_W-1:0]                      drop_count
);

    localparam int unsigned NP = NUM_EVENTS * NUM_THREADS;
    localparam int unsigned PW = (NP > 1) ? $clog2(NP) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    barrier_t        bar_reg [NUM_THREADS];
    logic [NP-1:0]   pend_vec;
    logic [NP-1:0]   drop_vec;
    logic [NP-1:0]   grant;
    perf_record_t    slot_arr [NP];
    logic [PW-1:0]   grant_idx;
    logic            arb_en, push, pop, full, empty;
    logic [AW:0]     wr_ptr, rd_ptr;
    perf_record_t    fifo_mem [FIFO_DEPTH];
    logic [PW:0]     drop_inc;
    logic [DROP_W:0] drop_sum;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int unsigned i = 0; i < NUM_THREADS; i++) bar_reg[i] <= '0;
        end else if (bar_capture_valid) begin
            bar_reg[bar_capture_thread] <= bar_capture_id;
        end
    end

    for (genvar e = 0; e < NUM_EVENTS; e++) begin : g_evt
        for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
            localparam int unsigned P = e * NUM_THREADS + t;

            logic [CNT_W-1:0] cnt;
            logic             sat, pending, ev, int_end;
            perf_record_t     slot;

            assign ev          = perf_events[e][t];
            assign int_end     = enable && !ev && (cnt != '0);
            assign drop_vec[P] = int_end && pending && !grant[P];
            assign pend_vec[P] = pending;
            assign slot_arr[P] = slot;

            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    cnt     <= '0;
                    sat     <= 1'b0;
                    pending <= 1'b0;
                    slot    <= '0;
                end else begin
                    if (enable && ev) begin
                        if (cnt == '1) sat <= 1'b1;
                        else           cnt <= cnt + CNT_W'(1);
                    end else if (int_end) begin
                        cnt <= '0;
                        sat <= 1'b0;
                    end
                    // A grant this cycle empties the slot, so a new record may take it
                    if (int_end && !drop_vec[P]) begin
                        pending <= 1'b1;
                        slot    <= make_record(TILE_ID_PAR, t, e, bar_reg[t],
                                               PERF_CNT_W_MAX'(cnt), sat);
                    end else if (grant[P]) begin
                        pending <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        drop_inc = '0;
        for (int unsigned i = 0; i < NP; i++) drop_inc = drop_inc + (PW + 1)'(drop_vec[i]);
    end

    assign drop_sum = {1'b0, drop_count} + (DROP_W + 1)'(drop_inc);

    always_ff @(posedge clk) begin
        if (reset || clear)      drop_count <= '0;
        else if (drop_sum[DROP_W]) drop_count <= '1;
        else                     drop_count <= drop_sum[DROP_W-1:0];
    end

    perf_rr_arbiter #(.N(NP)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .en        (arb_en),
        .req       (pend_vec),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop    = !empty && rec_if.rec_ready;
    assign arb_en = !full || pop;
    assign push   = |grant;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= slot_arr[grant_idx];
    end

    assign rec_if.rec_valid = !empty;
    assign rec_if.rec_data  = fifo_mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_sync_perf_monitor.sv
// Directed bench for sync_perf_monitor: a default instance plus a 4-bit-counter instance.
module tb_sync_perf_monitor;
    import sync_perf_monitor_pkg::*;

    logic            clk = 1'b0;
    logic            reset, enable, clear;
    logic [1:0][7:0] perf_events, ev_s;
    logic            bar_capture_valid;
    logic [2:0]      bar_capture_thread;
    barrier_t        bar_capture_id;
    logic [15:0]     drop_count, drop_s;
    int              total = 0;
    int              bad   = 0;

    sync_perf_monitor_if bus ();
    sync_perf_monitor_if bus_s ();

    sync_perf_monitor #(
        .TILE_ID_PAR (3), .NUM_THREADS (8), .NUM_EVENTS (2),
        .CNT_W (32), .FIFO_DEPTH (8), .DROP_W (16)
    ) u_dut (
        .clk (clk), .reset (reset), .enable (enable), .clear (clear),
        .perf_events (perf_events), .bar_capture_valid (bar_capture_valid),
        .bar_capture_thread (bar_capture_thread), .bar_capture_id (bar_capture_id),
        .rec_if (bus), .drop_count (drop_count)
    );

    sync_perf_monitor #(
        .TILE_ID_PAR (9), .NUM_THREADS (8), .NUM_EVENTS (2),
        .CNT_W (4), .FIFO_DEPTH (8), .DROP_W (16)
    ) u_sat (
        .clk (clk), .reset (reset), .enable (enable), .clear (clear),
        .perf_events (ev_s), .bar_capture_valid (bar_capture_valid),
        .bar_capture_thread (bar_capture_thread), .bar_capture_id (bar_capture_id),
        .rec_if (bus_s), .drop_count (drop_s)
    );

    always #5 clk = ~clk;

    function automatic perf_record_t mkrec(input int tile, input int thr, input int evt,
                                           input int bar, input longint cnt, input bit s);
        perf_record_t r;
        r.tile_id    = 8'(tile);
        r.thread_idx = 8'(thr);
        r.event_idx  = 4'(evt);
        r.barrier    = 8'(bar);
        r.count      = 32'(cnt);
        r.saturated  = s;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_rec(input string tag, input perf_record_t exp);
        int n = 0;
        while (!bus.rec_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 64'(bus.rec_valid), 64'd1);
        chk(tag, 64'(bus.rec_data), 64'(exp));
        bus.rec_ready = 1'b1;
        tick();
        bus.rec_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; clear = 1'b0;
        perf_events = '0; ev_s = '0;
        bar_capture_valid = 1'b0; bar_capture_thread = '0; bar_capture_id = '0;
        bus.rec_ready = 1'b0; bus_s.rec_ready = 1'b0;
        repeat (2) tick();
        chk("rst_valid", 64'(bus.rec_valid), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        chk("rst_valid_s", 64'(bus_s.rec_valid), 64'd0);
        reset = 1'b0;
        tick();

        // Thread 2, detect event, 5 high cycles, barrier 7
        bar_capture_valid = 1'b1; bar_capture_thread = 3'd2; bar_capture_id = 8'd7;
        tick();
        bar_capture_valid = 1'b0;
        perf_events[0][2] = 1'b1;
        repeat (5) tick();
        perf_events[0][2] = 1'b0;
        tick();
        chk("t1_lat1", 64'(bus.rec_valid), 64'd0);
        tick();
        chk("t1_lat2", 64'(bus.rec_valid), 64'd1);
        chk("t1_rec", 64'(bus.rec_data), 64'(mkrec(3, 2, PERF_EVENT_DETECT, 7, 5, 0)));
        bus.rec_ready = 1'b1;
        tick();
        bus.rec_ready = 1'b0;
        chk("t1_popped", 64'(bus.rec_valid), 64'd0);

        // 1-low-1 pulse on thread 0
        perf_events[0][0] = 1'b1; tick();
        perf_events[0][0] = 1'b0; tick();
        perf_events[0][0] = 1'b1; tick();
        perf_events[0][0] = 1'b0; tick();
        expect_rec("pulse_a", mkrec(3, 0, 0, 0, 1, 0));
        expect_rec("pulse_b", mkrec(3, 0, 0, 0, 1, 0));
        chk("pulse_empty", 64'(bus.rec_valid), 64'd0);

        // 4-bit counter: 20 cycles saturates, 15 cycles does not
        ev_s[0][0] = 1'b1; repeat (20) tick();
        ev_s[0][0] = 1'b0; repeat (2) tick();
        chk("sat20_valid", 64'(bus_s.rec_valid), 64'd1);
        chk("sat20_rec", 64'(bus_s.rec_data), 64'(mkrec(9, 0, 0, 0, 15, 1)));
        bus_s.rec_ready = 1'b1; tick(); bus_s.rec_ready = 1'b0;
        ev_s[0][0] = 1'b1; repeat (15) tick();
        ev_s[0][0] = 1'b0; repeat (2) tick();
        chk("sat15_rec", 64'(bus_s.rec_data), 64'(mkrec(9, 0, 0, 0, 15, 0)));
        bus_s.rec_ready = 1'b1; tick(); bus_s.rec_ready = 1'b0;
        chk("sat_empty", 64'(bus_s.rec_valid), 64'd0);

        // Clear resets the RR pointer and barrier regs, then all 16 pairs end together
        clear = 1'b1; tick(); clear = 1'b0;
        bar_capture_valid = 1'b1; bar_capture_thread = 3'd5; bar_capture_id = 8'h33;
        tick();
        bar_capture_valid = 1'b0;
        perf_events = '1; repeat (3) tick();
        perf_events = '0; tick();
        for (int p = 0; p < 16; p++)
            expect_rec($sformatf("burst%0d", p),
                       mkrec(3, p % 8, p / 8, (p % 8 == 5) ? 8'h33 : 0, 3, 0));
        chk("burst_drop", 64'(drop_count), 64'd0);
        chk("burst_empty", 64'(bus.rec_valid), 64'd0);

        // Backpressure: 10 intervals, FIFO holds 8, 2 stay pending
        perf_events = 16'h03FF; repeat (2) tick();
        perf_events = '0; tick();
        repeat (8) tick();
        chk("bp_valid", 64'(bus.rec_valid), 64'd1);
        chk("bp_drop0", 64'(drop_count), 64'd0);
        perf_events[1][0] = 1'b1; tick();
        perf_events[1][0] = 1'b0; tick();
        chk("bp_drop1", 64'(drop_count), 64'd1);
        for (int p = 0; p < 10; p++)
            expect_rec($sformatf("bp%0d", p),
                       mkrec(3, p % 8, p / 8, (p % 8 == 5) ? 8'h33 : 0, 2, 0));
        chk("bp_empty", 64'(bus.rec_valid), 64'd0);
        chk("bp_drop_hold", 64'(drop_count), 64'd1);

        // enable=0 freezes the counter and suppresses the interval end
        perf_events[1][1] = 1'b1; repeat (2) tick();
        enable = 1'b0; perf_events[1][1] = 1'b0; repeat (3) tick();
        chk("en_frozen", 64'(bus.rec_valid), 64'd0);
        perf_events[1][1] = 1'b1; tick();
        enable = 1'b1; tick();
        perf_events[1][1] = 1'b0;
        expect_rec("en_rec", mkrec(3, 1, PERF_EVENT_SEND, 0, 3, 0));

        // Capture coinciding with an interval end uses the old barrier id
        perf_events[0][4] = 1'b1; tick();
        perf_events[0][4] = 1'b0;
        bar_capture_valid = 1'b1; bar_capture_thread = 3'd4; bar_capture_id = 8'h99;
        tick();
        bar_capture_valid = 1'b0;
        expect_rec("cap_old", mkrec(3, 4, 0, 0, 1, 0));
        perf_events[0][4] = 1'b1; tick();
        perf_events[0][4] = 1'b0;
        expect_rec("cap_new", mkrec(3, 4, 0, 8'h99, 1, 0));

        // Fill FIFO and pending slots, force drops, then clear mid-interval
        perf_events = 16'h03FF; tick();
        perf_events = '0; tick();
        repeat (9) tick();
        perf_events = 16'h03FF; tick();
        perf_events = '0; tick();
        chk("pre_clr_drop", 64'(drop_count), 64'd3);
        chk("pre_clr_valid", 64'(bus.rec_valid), 64'd1);
        perf_events[1][3] = 1'b1; repeat (2) tick();
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_valid", 64'(bus.rec_valid), 64'd0);
        chk("clr_drop", 64'(drop_count), 64'd0);
        repeat (3) tick();
        chk("clr_no_stale", 64'(bus.rec_valid), 64'd0);
        perf_events[1][3] = 1'b0;
        expect_rec("clr_restart", mkrec(3, 3, 1, 0, 3, 0));
        repeat (3) tick();
        chk("clr_final_empty", 64'(bus.rec_valid), 64'd0);
        chk("sat_inst_drop", 64'(drop_s), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
